// File: rtl/helai_video_to_axis.sv
// helai_video_to_axis: scaler vs/de/pixel stream to AXI4-Stream video (tuser=SOF, tlast=EOL) via a drop-on-overflow FIFO.
// Optional `VID2AXIS_LINE_CHECK_EN adds sticky short-line detection on o_line_err.
module helai_video_to_axis #(
    parameter int DATA_WIDTH        = 8,
    parameter int CHANNELS          = 1,
    parameter int INPUT_X_RES_WIDTH = 11,
    parameter int FIFO_AW           = 10
) (
    input  logic                           i_video_pclk,
    input  logic                           i_reset_n,
    input  logic [INPUT_X_RES_WIDTH-1:0]   i_video_width,
    input  logic                           i_video_vs,
    input  logic                           i_video_de,
    input  logic [DATA_WIDTH*CHANNELS-1:0] i_video_pixel,
    output logic [DATA_WIDTH*CHANNELS-1:0] m_axis_tdata,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tuser,
    output logic                           m_axis_tlast,
    output logic                           o_overflow,
    output logic                           o_line_err
);
    localparam int PW    = DATA_WIDTH * CHANNELS;
    localparam int EW    = PW + 2;
    localparam int XW    = INPUT_X_RES_WIDTH;
    localparam int DEPTH = 2 ** FIFO_AW;

    typedef enum logic [1:0] {WAIT_FRAME, ARMED, ACTIVE} state_t;

    state_t               state_q;
    logic                 vs_q;
    logic [XW-1:0]        x_q;
    logic                 ovf_q;
    logic [EW-1:0]        mem [DEPTH];
    logic [FIFO_AW-1:0]   wp_q;
    logic [FIFO_AW-1:0]   rp_q;
    logic [FIFO_AW:0]     cnt_q;
    logic                 val_q;
    logic [EW-1:0]        out_q;
    logic [FIFO_AW+1:0]   total;
    logic                 vs_rise;
    logic                 full;
    logic                 wr_en;
    logic                 rd;
    logic                 load;
    logic                 eol;
    logic                 sof;

    assign vs_rise = i_video_vs & ~vs_q;
    // Output register counts toward occupancy so total storage is exactly DEPTH.
    assign total   = {1'b0, cnt_q} + {{(FIFO_AW + 1){1'b0}}, val_q};
    assign full    = total == (FIFO_AW + 2)'(DEPTH);
    assign wr_en   = i_video_de & (state_q != WAIT_FRAME) & ~vs_rise & ~full;
    assign rd      = val_q & m_axis_tready;
    assign load    = (~val_q | rd) & (cnt_q != '0);
    assign eol     = (i_video_width <= XW'(1)) | (x_q == i_video_width - XW'(1));
    assign sof     = state_q == ARMED;

`ifdef VID2AXIS_LINE_CHECK_EN
    logic de_q;
    logic lerr_q;
    logic short_line;

    assign short_line = (x_q != '0) & ((~i_video_de & de_q) | (vs_rise & (state_q == ACTIVE)));
    assign o_line_err = lerr_q;

    always_ff @(posedge i_video_pclk) begin
        if (!i_reset_n) begin
            de_q   <= 1'b0;
            lerr_q <= 1'b0;
        end else begin
            de_q <= i_video_de;
            if (short_line)
                lerr_q <= 1'b1;
        end
    end
`else
    assign o_line_err = 1'b0;
`endif

    always_ff @(posedge i_video_pclk) begin
        if (!i_reset_n) begin
            state_q <= WAIT_FRAME;
            vs_q    <= 1'b0;
            x_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            vs_q <= i_video_vs;
            if (vs_rise) begin
                state_q <= ARMED;
                x_q     <= '0;
            end else if (i_video_de && state_q != WAIT_FRAME) begin
                if (full) begin
                    ovf_q   <= 1'b1;
                    state_q <= WAIT_FRAME;
                    x_q     <= '0;
                end else begin
                    state_q <= ACTIVE;
                    x_q     <= eol ? '0 : x_q + 1'b1;
                end
            end
`ifdef VID2AXIS_LINE_CHECK_EN
            else if (short_line)
                x_q <= '0;
`endif
        end
    end

    always_ff @(posedge i_video_pclk) begin
        if (wr_en)
            mem[wp_q] <= {sof, eol, i_video_pixel};
    end

    always_ff @(posedge i_video_pclk) begin
        if (!i_reset_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            val_q <= 1'b0;
            out_q <= '0;
        end else begin
            if (wr_en)
                wp_q <= wp_q + 1'b1;
            if (load)
                rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + {{FIFO_AW{1'b0}}, wr_en} - {{FIFO_AW{1'b0}}, load};
            if (load) begin
                val_q <= 1'b1;
                out_q <= mem[rp_q];
            end else if (rd)
                val_q <= 1'b0;
        end
    end

    assign m_axis_tdata  = out_q[PW-1:0];
    assign m_axis_tlast  = out_q[PW];
    assign m_axis_tuser  = out_q[PW+1];
    assign m_axis_tvalid = val_q;
    assign o_overflow    = ovf_q;
endmodule

// File: tb/tb_helai_video_to_axis.sv
// tb_helai_video_to_axis: directed scenarios for helai_video_to_axis with a 16-entry FIFO.
// Expectations for the short-line scenario follow `VID2AXIS_LINE_CHECK_EN when it is defined.
module tb_helai_video_to_axis;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] width = 11'd4;
    logic        vs = 1'b0;
    logic        de = 1'b0;
    logic [7:0]  pix = 8'h00;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tready = 1'b0;
    logic        tuser;
    logic        tlast;
    logic        ovf;
    logic        lerr;
    logic [9:0]  q [$];
    int          cmp = 0;
    int          bad = 0;

    helai_video_to_axis #(
        .DATA_WIDTH(8), .CHANNELS(1), .INPUT_X_RES_WIDTH(11), .FIFO_AW(4)
    ) dut (
        .i_video_pclk(clk), .i_reset_n(rst_n), .i_video_width(width),
        .i_video_vs(vs), .i_video_de(de), .i_video_pixel(pix),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tuser(tuser), .m_axis_tlast(tlast),
        .o_overflow(ovf), .o_line_err(lerr)
    );

    always #5 clk = ~clk;

    // Beat capture {tuser, tlast, tdata}; handshake completes at the following posedge.
    always @(negedge clk)
        if (tvalid && tready)
            q.push_back({tuser, tlast, tdata});

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic vs_pulse();
        vs = 1'b1;
        cyc(1);
        vs = 1'b0;
        cyc(1);
    endtask

    task automatic line(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            de = 1'b1;
            pix = base + 8'(i);
            cyc(1);
        end
        de = 1'b0;
        cyc(2);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        vs = 1'b0;
        de = 1'b0;
        tready = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        de = 1'b1;
        vs = 1'b1;
        tready = 1'b1;
        cyc(3);
        @(negedge clk);
        cmp++;
        if ({tvalid, tuser, tlast, tdata, ovf, lerr} !== 13'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", {tvalid, tuser, tlast, tdata, ovf, lerr});
        end
        de = 1'b0;
        vs = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        q.delete();
    endtask

    task automatic test_basic();
        do_reset();
        width = 11'd4;
        tready = 1'b1;
        vs_pulse();
        for (int l = 0; l < 3; l++)
            line(4, 8'(l * 16));
        cyc(10);
        cmp++;
        if (q.size() !== 12) begin
            bad++;
            $display("FAIL basic_count: got %0d want 12", q.size());
        end
        for (int k = 0; k < 12 && k < q.size(); k++) begin
            cmp++;
            if (q[k] !== {k == 0, k % 4 == 3, 8'((k / 4) * 16 + k % 4)}) begin
                bad++;
                $display("FAIL basic_beat%0d: got %h want %h", k, q[k], {k == 0, k % 4 == 3, 8'((k / 4) * 16 + k % 4)});
            end
        end
    endtask

    task automatic test_latency();
        do_reset();
        width = 11'd4;
        tready = 1'b1;
        line(3, 8'h10);
        cyc(5);
        cmp++;
        if (q.size() !== 0 || tvalid !== 1'b0) begin
            bad++;
            $display("FAIL pre_vs_discard: got %0d beats want 0", q.size());
        end
        vs_pulse();
        de = 1'b1;
        pix = 8'hA5;
        cyc(1);
        de = 1'b0;
        @(negedge clk);
        cmp++;
        if (tvalid !== 1'b0) begin
            bad++;
            $display("FAIL latency_n1: got tvalid %b want 0", tvalid);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        cmp++;
        if ({tvalid, tuser, tlast, tdata} !== {3'b110, 8'hA5}) begin
            bad++;
            $display("FAIL latency_n2: got %h want %h", {tvalid, tuser, tlast, tdata}, {3'b110, 8'hA5});
        end
        cyc(3);
        cmp++;
        if (q.size() !== 1) begin
            bad++;
            $display("FAIL latency_count: got %0d want 1", q.size());
        end
    endtask

    task automatic test_overflow();
        do_reset();
        width = 11'd8;
        tready = 1'b0;
        vs_pulse();
        line(20, 8'h00);
        line(3, 8'h70);
        @(negedge clk);
        cmp++;
        if ({ovf, tvalid, tuser, tlast, tdata} !== {4'b1110, 8'h00}) begin
            bad++;
            $display("FAIL ovf_hold: got %h want %h", {ovf, tvalid, tuser, tlast, tdata}, {4'b1110, 8'h00});
        end
        @(posedge clk);
        #1;
        tready = 1'b1;
        cyc(30);
        cmp++;
        if (q.size() !== 16) begin
            bad++;
            $display("FAIL ovf_count: got %0d want 16", q.size());
        end
        for (int k = 0; k < 16 && k < q.size(); k++) begin
            cmp++;
            if (q[k] !== {k == 0, k % 8 == 7, 8'(k)}) begin
                bad++;
                $display("FAIL ovf_beat%0d: got %h want %h", k, q[k], {k == 0, k % 8 == 7, 8'(k)});
            end
        end
        q.delete();
        vs_pulse();
        line(4, 8'h40);
        cyc(8);
        cmp++;
        if (q.size() !== 4 || ovf !== 1'b1) begin
            bad++;
            $display("FAIL resync_count: got %0d ovf %b want 4 ovf 1", q.size(), ovf);
        end
        if (q.size() == 4) begin
            cmp++;
            if (q[0] !== {2'b10, 8'h40} || q[3] !== {2'b00, 8'h43}) begin
                bad++;
                $display("FAIL resync_beats: got %h %h want 240 043", q[0], q[3]);
            end
        end
    endtask

    task automatic test_stall();
        logic       stall;
        logic [9:0] prev;
        do_reset();
        width = 11'd8;
        stall = 1'b0;
        prev = '0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            tready = c[0];
            vs = (c == 0);
            de = (c >= 2 && c < 10) || (c >= 12 && c < 20);
            pix = 8'(c < 10 ? c + 126 : c + 124);
            @(negedge clk);
            if (stall) begin
                cmp++;
                if ({tvalid, tuser, tlast, tdata} !== {1'b1, prev}) begin
                    bad++;
                    $display("FAIL stall_stable c%0d: got %h want %h", c, {tvalid, tuser, tlast, tdata}, {1'b1, prev});
                end
            end
            prev = {tuser, tlast, tdata};
            stall = tvalid & ~tready;
        end
        @(posedge clk);
        #1;
        vs = 1'b0;
        de = 1'b0;
        cmp++;
        if (q.size() !== 16) begin
            bad++;
            $display("FAIL stall_count: got %0d want 16", q.size());
        end
        for (int k = 0; k < 16 && k < q.size(); k++) begin
            cmp++;
            if (q[k] !== {k == 0, k % 8 == 7, 8'(8'h80 + k)}) begin
                bad++;
                $display("FAIL stall_beat%0d: got %h want %h", k, q[k], {k == 0, k % 8 == 7, 8'(8'h80 + k)});
            end
        end
    endtask

    task automatic test_vs_de();
        do_reset();
        width = 11'd2;
        tready = 1'b1;
        vs = 1'b1;
        de = 1'b1;
        pix = 8'h11;
        cyc(1);
        vs = 1'b0;
        pix = 8'h22;
        cyc(1);
        pix = 8'h33;
        cyc(1);
        de = 1'b0;
        cyc(6);
        width = 11'd1;
        vs_pulse();
        line(3, 8'h60);
        cyc(6);
        cmp++;
        if (q.size() !== 5) begin
            bad++;
            $display("FAIL vsde_count: got %0d want 5", q.size());
        end
        if (q.size() == 5) begin
            cmp++;
            if (q[0] !== {2'b10, 8'h22} || q[1] !== {2'b01, 8'h33}) begin
                bad++;
                $display("FAIL vsde_beats: got %h %h want 222 133", q[0], q[1]);
            end
            cmp++;
            if (q[2] !== {2'b11, 8'h60} || q[3] !== {2'b01, 8'h61} || q[4] !== {2'b01, 8'h62}) begin
                bad++;
                $display("FAIL width1_beats: got %h %h %h want 360 161 162", q[2], q[3], q[4]);
            end
        end
    endtask

    task automatic test_line_check();
        int  eb;
        logic le;
`ifdef VID2AXIS_LINE_CHECK_EN
        eb = 12;
        le = 1'b1;
`else
        eb = 7;
        le = 1'b0;
`endif
        do_reset();
        width = 11'd8;
        tready = 1'b1;
        vs_pulse();
        line(5, 8'h50);
        cyc(1);
        line(8, 8'h60);
        cyc(8);
        cmp++;
        if (lerr !== le) begin
            bad++;
            $display("FAIL line_err: got %b want %b", lerr, le);
        end
        cmp++;
        if (q.size() !== 13) begin
            bad++;
            $display("FAIL line_count: got %0d want 13", q.size());
        end
        for (int k = 0; k < 13 && k < q.size(); k++) begin
            cmp++;
            if (q[k] !== {k == 0, k == eb, 8'(k < 5 ? 8'h50 + k : 8'h5B + k)}) begin
                bad++;
                $display("FAIL line_beat%0d: got %h want %h", k, q[k], {k == 0, k == eb, 8'(k < 5 ? 8'h50 + k : 8'h5B + k)});
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        width = 11'd8;
        tready = 1'b0;
        vs_pulse();
        line(4, 8'h90);
        @(negedge clk);
        cmp++;
        if (tvalid !== 1'b1) begin
            bad++;
            $display("FAIL mid_valid: got %b want 1", tvalid);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        cyc(1);
        @(negedge clk);
        cmp++;
        if (tvalid !== 1'b0) begin
            bad++;
            $display("FAIL mid_drop: got %b want 0", tvalid);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tready = 1'b1;
        cyc(10);
        cmp++;
        if (q.size() !== 0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL mid_flush: got %0d beats ovf %b want 0 0", q.size(), ovf);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_overflow();
        test_stall();
        test_vs_de();
        test_line_check();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
